// File: rtl/control_pkg.sv
// Shared encodings for the control unit: FSM states, opcodes, bus select codes
// and the one-hot instruction-class vector produced by the opcode decoder.
package control_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FET1,
        ST_FET2,
        ST_DEC,
        ST_EX1,
        ST_RD1,
        ST_RD2,
        ST_WR1,
        ST_WR2,
        ST_BR1,
        ST_BR2,
        ST_HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_NOT  = 4'b0100;
    localparam logic [3:0] OP_RD   = 4'b0101;
    localparam logic [3:0] OP_WR   = 4'b0110;
    localparam logic [3:0] OP_BR   = 4'b0111;
    localparam logic [3:0] OP_BRZ  = 4'b1000;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [2:0] BUS1_R0 = 3'd0;
    localparam logic [2:0] BUS1_R1 = 3'd1;
    localparam logic [2:0] BUS1_R2 = 3'd2;
    localparam logic [2:0] BUS1_R3 = 3'd3;
    localparam logic [2:0] BUS1_PC = 3'd4;

    localparam logic [1:0] BUS2_ALU  = 2'd0;
    localparam logic [1:0] BUS2_BUS1 = 2'd1;
    localparam logic [1:0] BUS2_MEM  = 2'd2;

    typedef struct packed {
        logic nop;
        logic alu;
        logic inv;
        logic rd;
        logic wr;
        logic br;
        logic brz;
        logic halt;
        logic illegal;
    } instr_class_t;

    localparam int unsigned CLS_W = $bits(instr_class_t);

endpackage

// File: rtl/control_opcode_decode.sv
// Maps a 4-bit opcode to exactly one instruction-class flag; unassigned
// opcodes raise the illegal flag and the FSM decides how to treat them.
module control_opcode_decode
    import control_pkg::*;
(
    input  logic [3:0]       opcode,
    output logic [CLS_W-1:0] cls
);

    instr_class_t c;

    always_comb begin
        c = '0;
        case (opcode)
            OP_NOP:                 c.nop     = 1'b1;
            OP_ADD, OP_SUB, OP_AND: c.alu     = 1'b1;
            OP_NOT:                 c.inv     = 1'b1;
            OP_RD:                  c.rd      = 1'b1;
            OP_WR:                  c.wr      = 1'b1;
            OP_BR:                  c.br      = 1'b1;
            OP_BRZ:                 c.brz     = 1'b1;
            OP_HALT:                c.halt    = 1'b1;
            default:                c.illegal = 1'b1;
        endcase
    end

    assign cls = c;

endmodule

// File: rtl/control_unit.sv
// Multi-cycle datapath controller: fetch/decode/execute FSM with combinational
// strobes. Optional macro CTRL_ILLEGAL_TRAP_EN traps unassigned opcodes into HALT.
module control_unit
    import control_pkg::*;
#(
    parameter int unsigned WS      = 8,
    parameter int unsigned STATE_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [WS-1:0] instruction,
    input  logic          zero,
    output logic          load_r0,
    output logic          load_r1,
    output logic          load_r2,
    output logic          load_r3,
    output logic          load_pc,
    output logic          inc_pc,
    output logic [2:0]    sel_bus_1_mux,
    output logic [1:0]    sel_bus_2_mux,
    output logic          load_ir,
    output logic          load_add_r,
    output logic          load_reg_y,
    output logic          load_reg_z,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output logic          err_illegal,
`endif
    output logic          write
);

    logic [3:0]         opcode;
    logic [1:0]         src;
    logic [1:0]         dest;
    logic [CLS_W-1:0]   cls_bits;
    instr_class_t       cls;
    logic [STATE_W-1:0] state_q;
    state_t             state;
    state_t             next_state;
    logic [3:0]         load_r;

    assign opcode = instruction[WS-1:WS-4];
    assign src    = instruction[3:2];
    assign dest   = instruction[1:0];

    control_opcode_decode u_decode (
        .opcode (opcode),
        .cls    (cls_bits)
    );

    assign cls   = instr_class_t'(cls_bits);
    assign state = state_t'(state_q[$bits(state_t)-1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STATE_W'(ST_IDLE);
        end else begin
            state_q <= STATE_W'(next_state);
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic set_err;
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (set_err) begin
            err_q <= 1'b1;
        end
    end

    assign err_illegal = err_q & ~rst;
`endif

    always_comb begin
        next_state    = state;
        load_r        = '0;
        load_pc       = 1'b0;
        inc_pc        = 1'b0;
        sel_bus_1_mux = '0;
        sel_bus_2_mux = '0;
        load_ir       = 1'b0;
        load_add_r    = 1'b0;
        load_reg_y    = 1'b0;
        load_reg_z    = 1'b0;
        write         = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        set_err       = 1'b0;
`endif
        // Reset is synchronous, so the state may still be mid-instruction
        // while rst is high; strobes are masked here rather than by state.
        if (!rst) begin
            case (state)
                ST_IDLE: next_state = ST_FET1;
                ST_FET1: begin
                    sel_bus_1_mux = BUS1_PC;
                    load_add_r    = 1'b1;
                    next_state    = ST_FET2;
                end
                ST_FET2: begin
                    sel_bus_2_mux = BUS2_MEM;
                    load_ir       = 1'b1;
                    inc_pc        = 1'b1;
                    next_state    = ST_DEC;
                end
                ST_DEC: begin
                    if (cls.alu) begin
                        sel_bus_1_mux = {1'b0, src};
                        load_reg_y    = 1'b1;
                        next_state    = ST_EX1;
                    end else if (cls.inv) begin
                        sel_bus_1_mux = {1'b0, src};
                        load_reg_z    = 1'b1;
                        sel_bus_2_mux = BUS2_ALU;
                        load_r        = 4'b0001 << dest;
                        next_state    = ST_FET1;
                    end else if (cls.rd || cls.wr || cls.br || (cls.brz && zero)) begin
                        sel_bus_1_mux = BUS1_PC;
                        load_add_r    = 1'b1;
                        if (cls.rd) begin
                            next_state = ST_RD1;
                        end else if (cls.wr) begin
                            next_state = ST_WR1;
                        end else begin
                            next_state = ST_BR1;
                        end
                    end else if (cls.brz) begin
                        // Untaken branch skips the inline target word.
                        inc_pc     = 1'b1;
                        next_state = ST_FET1;
                    end else if (cls.halt) begin
                        next_state = ST_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    end else if (cls.illegal) begin
                        set_err    = 1'b1;
                        next_state = ST_HALT;
`endif
                    end else begin
                        next_state = ST_FET1;
                    end
                end
                ST_EX1: begin
                    sel_bus_1_mux = {1'b0, dest};
                    load_reg_z    = 1'b1;
                    sel_bus_2_mux = BUS2_ALU;
                    load_r        = 4'b0001 << dest;
                    next_state    = ST_FET1;
                end
                ST_RD1, ST_WR1: begin
                    sel_bus_2_mux = BUS2_MEM;
                    load_add_r    = 1'b1;
                    inc_pc        = 1'b1;
                    next_state    = (state == ST_RD1) ? ST_RD2 : ST_WR2;
                end
                ST_RD2: begin
                    sel_bus_2_mux = BUS2_MEM;
                    load_r        = 4'b0001 << dest;
                    next_state    = ST_FET1;
                end
                ST_WR2: begin
                    sel_bus_1_mux = {1'b0, src};
                    write         = 1'b1;
                    next_state    = ST_FET1;
                end
                ST_BR1: begin
                    sel_bus_2_mux = BUS2_MEM;
                    load_add_r    = 1'b1;
                    next_state    = ST_BR2;
                end
                ST_BR2: begin
                    sel_bus_2_mux = BUS2_MEM;
                    load_pc       = 1'b1;
                    next_state    = ST_FET1;
                end
                ST_HALT: next_state = ST_HALT;
                default: next_state = ST_IDLE;
            endcase
        end
    end

    assign load_r0 = load_r[0];
    assign load_r1 = load_r[1];
    assign load_r2 = load_r[2];
    assign load_r3 = load_r[3];

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: each instruction is expanded into its
// expected per-cycle strobe sequence and compared cycle by cycle.
module tb_control_unit;

    localparam logic [2:0] B1_PC  = 3'd4;
    localparam logic [1:0] B2_ALU = 2'd0;
    localparam logic [1:0] B2_MEM = 2'd2;
    localparam logic       H      = 1'b1;
    localparam logic       L      = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] instruction = '0;
    logic       zero = 1'b0;
    logic       load_r0, load_r1, load_r2, load_r3;
    logic       load_pc, inc_pc;
    logic [2:0] sel_bus_1_mux;
    logic [1:0] sel_bus_2_mux;
    logic       load_ir, load_add_r, load_reg_y, load_reg_z, write;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic       err_illegal;
`endif

    control_unit #(.WS(8), .STATE_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .instruction   (instruction),
        .zero          (zero),
        .load_r0       (load_r0),
        .load_r1       (load_r1),
        .load_r2       (load_r2),
        .load_r3       (load_r3),
        .load_pc       (load_pc),
        .inc_pc        (inc_pc),
        .sel_bus_1_mux (sel_bus_1_mux),
        .sel_bus_2_mux (sel_bus_2_mux),
        .load_ir       (load_ir),
        .load_add_r    (load_add_r),
        .load_reg_y    (load_reg_y),
        .load_reg_z    (load_reg_z),
`ifdef CTRL_ILLEGAL_TRAP_EN
        .err_illegal   (err_illegal),
`endif
        .write         (write)
    );

    always #5 clk = ~clk;

    logic [15:0] obs;
    assign obs = {load_r3, load_r2, load_r1, load_r0, load_pc, inc_pc, sel_bus_1_mux,
                  sel_bus_2_mux, load_ir, load_add_r, load_reg_y, load_reg_z, write};

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    logic [16:0] exp_q[$];
    logic        model_err = 1'b0;
    logic        halted;

    function automatic logic [15:0] mk(input logic [3:0] lr, input logic lpc, input logic ipc,
                                       input logic [2:0] s1, input logic [1:0] s2, input logic ir,
                                       input logic ar, input logic y, input logic z, input logic w);
        return {lr, lpc, ipc, s1, s2, ir, ar, y, z, w};
    endfunction

    // Expected behaviour of one instruction from FET1 up to (not including) the next FET1.
    task automatic build(input logic [7:0] ins, input logic z, output logic halts);
        logic [3:0]  op;
        logic [2:0]  s1_src, s1_dst;
        logic [3:0]  lr;
        logic [15:0] br_dec;
        op     = ins[7:4];
        s1_src = {1'b0, ins[3:2]};
        s1_dst = {1'b0, ins[1:0]};
        lr     = 4'b0001 << ins[1:0];
        br_dec = mk(4'b0, L, L, B1_PC, B2_ALU, L, H, L, L, L);
        halts  = 1'b0;
        exp_q.push_back({model_err, mk(4'b0, L, L, B1_PC, B2_ALU, L, H, L, L, L)});
        exp_q.push_back({model_err, mk(4'b0, L, H, 3'd0, B2_MEM, H, L, L, L, L)});
        case (op)
            4'd1, 4'd2, 4'd3: begin
                exp_q.push_back({model_err, mk(4'b0, L, L, s1_src, B2_ALU, L, L, H, L, L)});
                exp_q.push_back({model_err, mk(lr, L, L, s1_dst, B2_ALU, L, L, L, H, L)});
            end
            4'd4: exp_q.push_back({model_err, mk(lr, L, L, s1_src, B2_ALU, L, L, L, H, L)});
            4'd5, 4'd6: begin
                exp_q.push_back({model_err, br_dec});
                exp_q.push_back({model_err, mk(4'b0, L, H, 3'd0, B2_MEM, L, H, L, L, L)});
                if (op == 4'd5)
                    exp_q.push_back({model_err, mk(lr, L, L, 3'd0, B2_MEM, L, L, L, L, L)});
                else
                    exp_q.push_back({model_err, mk(4'b0, L, L, s1_src, B2_ALU, L, L, L, L, H)});
            end
            4'd7, 4'd8: begin
                if (op == 4'd7 || z) begin
                    exp_q.push_back({model_err, br_dec});
                    exp_q.push_back({model_err, mk(4'b0, L, L, 3'd0, B2_MEM, L, H, L, L, L)});
                    exp_q.push_back({model_err, mk(4'b0, H, L, 3'd0, B2_MEM, L, L, L, L, L)});
                end else begin
                    exp_q.push_back({model_err, mk(4'b0, L, H, 3'd0, B2_ALU, L, L, L, L, L)});
                end
            end
            4'd15: begin
                exp_q.push_back({model_err, 16'h0000});
                halts = 1'b1;
            end
            4'd0: exp_q.push_back({model_err, 16'h0000});
            default: begin
                exp_q.push_back({model_err, 16'h0000});
                if (TRAP) begin
                    model_err = 1'b1;
                    halts     = 1'b1;
                end
            end
        endcase
    endtask

    task automatic step(input logic r, input logic [7:0] ins, input logic z,
                        input logic [16:0] e, input string tag);
        @(negedge clk);
        rst         = r;
        instruction = ins;
        zero        = z;
        #1;
        n_cmp++;
        assert (obs === e[15:0]) else begin
            n_fail++;
            $error("FAIL %s: outputs got %h expected %h (err model %b)", tag, obs, e[15:0], e[16]);
        end
        n_cmp++;
        assert ((($countones(obs[15:12]) <= 1) && !(obs[11] && obs[10])) === 1'b1) else begin
            n_fail++;
            $error("FAIL excl_%s: load_r %b load_pc %b inc_pc %b expected <=1 load_r, not both pc", tag,
                   obs[15:12], obs[11], obs[10]);
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        n_cmp++;
        assert (err_illegal === e[16]) else begin
            n_fail++;
            $error("FAIL err_%s: err_illegal got %b expected %b", tag, err_illegal, e[16]);
        end
`endif
    endtask

    task automatic run_instr(input logic [7:0] ins, input logic z, input string tag, output logic halts);
        logic [16:0] e;
        build(ins, z, halts);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            step(1'b0, ins, z, e, tag);
        end
    endtask

    task automatic do_reset(input string tag);
        step(1'b1, 8'($urandom), 1'($urandom), 17'h0, tag);
        model_err = 1'b0;
        step(1'b1, 8'($urandom), 1'($urandom), 17'h0, tag);
        step(1'b0, 8'h00, 1'b0, 17'h0, {tag, "_idle"});
    endtask

    initial begin
        logic [7:0]  ins;
        logic        z;
        logic [16:0] e;

        do_reset("reset");
        run_instr(8'h00, 1'b0, "nop", halted);
        run_instr(8'h16, 1'($urandom), "add", halted);
        run_instr(8'h80, 1'b0, "brz_nt", halted);
        run_instr(8'h80, 1'b1, "brz_t", halted);
        run_instr(8'h6C, 1'($urandom), "wr", halted);
        run_instr(8'h4E, 1'($urandom), "not", halted);

        for (int unsigned i = 0; i < 80; i++) begin
            ins = 8'($urandom);
            z   = 1'($urandom);
            if (ins[7:4] == 4'hF || (TRAP && ins[7:4] >= 4'h9 && ins[7:4] <= 4'hE))
                ins[7:4] = 4'($urandom_range(0, 8));
            run_instr(ins, z, "rand", halted);
        end

        // Reset arriving in RD1 must abandon the read without any register load.
        ins = 8'h5B;
        build(ins, 1'b0, halted);
        for (int unsigned i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            step(1'b0, ins, 1'b0, e, "rd_pre");
        end
        exp_q.delete();
        step(1'b1, ins, 1'b0, 17'h0, "rst_rd1");
        model_err = 1'b0;
        step(1'b0, ins, 1'b0, 17'h0, "idle_after_rd");
        run_instr(8'h00, 1'b0, "nop_after_rd", halted);

        run_instr(8'h90, 1'b0, "illegal", halted);
        if (halted) begin
            for (int unsigned i = 0; i < 10; i++)
                step(1'b0, 8'($urandom), 1'($urandom), {model_err, 16'h0000}, "illegal_halt");
            do_reset("rst_illegal");
        end
        run_instr(8'h16, 1'b0, "add_after_illegal", halted);

        run_instr(8'hF0, 1'b0, "halt", halted);
        for (int unsigned i = 0; i < 20; i++)
            step(1'b0, 8'($urandom), 1'($urandom), {model_err, 16'h0000}, "halt_hold");
        do_reset("rst_halt");
        run_instr(8'h00, 1'b0, "nop_after_halt", halted);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
